// File: rtl/param_burst_adaptor.sv
// param_burst_adaptor
//   Bridges a cache's line-wide memory port and a beat-wide physical memory bus.
//   A line writeback is serialised into a burst of BEATS beats. A line fill is
//   assembled from a burst of BEATS beats. Beats may be stalled by holding resp_i low.
//   With WRAP_EN=1 a fill starts at the beat that holds address_i and wraps
//   round the line, so the critical beat arrives first.
//
// Ports
//   clk, reset_n         clock (rising edge), asynchronous active-low reset
//   line_i / line_o      writeback line from cache / assembled fill line to cache
//   address_i            request byte address from cache
//   read_i / write_i     fill / writeback request (write wins if both are high)
//   resp_o               one-cycle completion pulse to cache
//   burst_i / burst_o    read beat from memory / write beat to memory
//   address_o            burst start address to memory (stable during a burst)
//   read_o / write_o     memory read / write request (held for the whole burst)
//   resp_i               beat accepted (write) or valid (read) from memory
module param_burst_adaptor #(
    parameter int unsigned LINE_W  = 256,
    parameter int unsigned BEAT_W  = 64,
    parameter int unsigned ADDR_W  = 32,
    parameter bit          WRAP_EN = 1'b0
) (
    input  logic              clk,
    input  logic              reset_n,
    input  logic [LINE_W-1:0] line_i,
    output logic [LINE_W-1:0] line_o,
    input  logic [ADDR_W-1:0] address_i,
    input  logic              read_i,
    input  logic              write_i,
    output logic              resp_o,
    input  logic [BEAT_W-1:0] burst_i,
    output logic [BEAT_W-1:0] burst_o,
    output logic [ADDR_W-1:0] address_o,
    output logic              read_o,
    output logic              write_o,
    input  logic              resp_i
);

    localparam int unsigned BEATS  = LINE_W / BEAT_W;
    localparam int unsigned OFF_W  = $clog2(LINE_W / 8);
    localparam int unsigned BOFF_W = $clog2(BEAT_W / 8);
    localparam int unsigned IDX_W  = (BEATS > 1) ? $clog2(BEATS) : 1;
    localparam int unsigned CNT_W  = $clog2(BEATS + 1);

    localparam logic [ADDR_W-1:0] LineMask = ~ADDR_W'((1 << OFF_W) - 1);
    localparam logic [ADDR_W-1:0] BeatMask = ~ADDR_W'((1 << BOFF_W) - 1);

    typedef enum logic [1:0] {StIdle, StRead, StWrite, StDone} state_e;

    state_e            state_q, state_d;
    logic [IDX_W-1:0]  idx_q, idx_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic [LINE_W-1:0] wline_q, wline_d;
    logic [LINE_W-1:0] rline_q, rline_d;
    logic [ADDR_W-1:0] addr_q, addr_d;

    logic [IDX_W-1:0]  start_idx;
    logic [IDX_W-1:0]  idx_inc;
    logic              last_beat;

    // Beat within the line that holds the requested byte (critical beat).
    assign start_idx = IDX_W'((address_i >> BOFF_W) & ADDR_W'(BEATS - 1));
    assign idx_inc   = (idx_q == IDX_W'(BEATS - 1)) ? '0 : idx_q + 1'b1;
    assign last_beat = resp_i && (cnt_q == CNT_W'(BEATS - 1));

    always_comb begin
        state_d = state_q;
        idx_d   = idx_q;
        cnt_d   = cnt_q;
        wline_d = wline_q;
        rline_d = rline_q;
        addr_d  = addr_q;
        case (state_q)
            StIdle: begin
                if (write_i) begin
                    wline_d = line_i;
                    addr_d  = address_i & LineMask;
                    idx_d   = '0;
                    cnt_d   = '0;
                    state_d = StWrite;
                end else if (read_i) begin
                    addr_d  = WRAP_EN ? (address_i & BeatMask) : (address_i & LineMask);
                    idx_d   = WRAP_EN ? start_idx : '0;
                    cnt_d   = '0;
                    state_d = StRead;
                end
            end
            StRead: begin
                if (resp_i) begin
                    rline_d[idx_q*BEAT_W +: BEAT_W] = burst_i;
                    idx_d = idx_inc;
                    cnt_d = cnt_q + 1'b1;
                    if (last_beat) begin
                        state_d = StDone;
                    end
                end
            end
            StWrite: begin
                if (resp_i) begin
                    idx_d = idx_inc;
                    cnt_d = cnt_q + 1'b1;
                    if (last_beat) begin
                        state_d = StDone;
                    end
                end
            end
            StDone: begin
                state_d = StIdle;
            end
            default: begin
                state_d = StIdle;
            end
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q <= StIdle;
            idx_q   <= '0;
            cnt_q   <= '0;
            wline_q <= '0;
            rline_q <= '0;
            addr_q  <= '0;
        end else begin
            state_q <= state_d;
            idx_q   <= idx_d;
            cnt_q   <= cnt_d;
            wline_q <= wline_d;
            rline_q <= rline_d;
            addr_q  <= addr_d;
        end
    end

    // Bus strobes decode straight from the state register, so they rise one
    // cycle after acceptance and fall the cycle after the last beat.
    assign read_o    = (state_q == StRead);
    assign write_o   = (state_q == StWrite);
    assign resp_o    = (state_q == StDone);
    assign address_o = addr_q;
    assign line_o    = rline_q;
    assign burst_o   = (state_q == StWrite) ? wline_q[idx_q*BEAT_W +: BEAT_W] : '0;

endmodule

// File: tb/tb_param_burst_adaptor.sv
module tb_param_burst_adaptor;

    logic clk = 1'b0;
    logic reset_n;
    always #5 clk = ~clk;

    int unsigned n_tests = 0;
    int unsigned n_fail  = 0;

    task automatic check_eq(input string tag, input logic [511:0] got, input logic [511:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        @(negedge clk);
    endtask

    // Default instance: 256/64, no wrap
    logic [255:0] d_line_i, d_line_o;
    logic [31:0]  d_address_i, d_address_o;
    logic         d_read_i, d_write_i, d_resp_o, d_read_o, d_write_o, d_resp_i;
    logic [63:0]  d_burst_i, d_burst_o;

    param_burst_adaptor u_dut (
        .clk      (clk),
        .reset_n  (reset_n),
        .line_i   (d_line_i),
        .line_o   (d_line_o),
        .address_i(d_address_i),
        .read_i   (d_read_i),
        .write_i  (d_write_i),
        .resp_o   (d_resp_o),
        .burst_i  (d_burst_i),
        .burst_o  (d_burst_o),
        .address_o(d_address_o),
        .read_o   (d_read_o),
        .write_o  (d_write_o),
        .resp_i   (d_resp_i)
    );

    // Wrapping instance: 256/64, WRAP_EN=1
    logic [255:0] w_line_i, w_line_o;
    logic [31:0]  w_address_i, w_address_o;
    logic         w_read_i, w_write_i, w_resp_o, w_read_o, w_write_o, w_resp_i;
    logic [63:0]  w_burst_i, w_burst_o;

    param_burst_adaptor #(.WRAP_EN(1'b1)) u_dut_wrap (
        .clk      (clk),
        .reset_n  (reset_n),
        .line_i   (w_line_i),
        .line_o   (w_line_o),
        .address_i(w_address_i),
        .read_i   (w_read_i),
        .write_i  (w_write_i),
        .resp_o   (w_resp_o),
        .burst_i  (w_burst_i),
        .burst_o  (w_burst_o),
        .address_o(w_address_o),
        .read_o   (w_read_o),
        .write_o  (w_write_o),
        .resp_i   (w_resp_i)
    );

    // Wide instance: 512/32, 16 beats
    logic [511:0] x_line_i, x_line_o;
    logic [31:0]  x_address_i, x_address_o;
    logic         x_read_i, x_write_i, x_resp_o, x_read_o, x_write_o, x_resp_i;
    logic [31:0]  x_burst_i, x_burst_o;

    param_burst_adaptor #(.LINE_W(512), .BEAT_W(32)) u_dut_wide (
        .clk      (clk),
        .reset_n  (reset_n),
        .line_i   (x_line_i),
        .line_o   (x_line_o),
        .address_i(x_address_i),
        .read_i   (x_read_i),
        .write_i  (x_write_i),
        .resp_o   (x_resp_o),
        .burst_i  (x_burst_i),
        .burst_o  (x_burst_o),
        .address_o(x_address_o),
        .read_o   (x_read_o),
        .write_o  (x_write_o),
        .resp_i   (x_resp_i)
    );

    // Sampled at the rising edge, before state updates land.
    int unsigned d_resp_cnt = 0, w_resp_cnt = 0, x_resp_cnt = 0, both_hi = 0;
    always @(posedge clk) begin
        if (d_resp_o) d_resp_cnt++;
        if (w_resp_o) w_resp_cnt++;
        if (x_resp_o) x_resp_cnt++;
        if ((d_read_o && d_write_o) || (w_read_o && w_write_o) || (x_read_o && x_write_o))
            both_hi++;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish, expected end of stimulus");
        $fatal(1);
    end

    logic [255:0] wl, exp_line;
    logic [511:0] exp_wide;
    logic [63:0]  mem [4];
    int unsigned  cnt_snap;

    initial begin
        reset_n = 1'b0;
        {d_line_i, d_address_i, d_read_i, d_write_i, d_burst_i, d_resp_i} = '0;
        {w_line_i, w_address_i, w_read_i, w_write_i, w_burst_i, w_resp_i} = '0;
        {x_line_i, x_address_i, x_read_i, x_write_i, x_burst_i, x_resp_i} = '0;
        @(negedge clk);
        check_eq("rst_line_o", d_line_o, '0);
        check_eq("rst_addr_o", d_address_o, '0);
        check_eq("rst_strobes", {d_read_o, d_write_o, d_resp_o}, 3'b000);
        check_eq("rst_burst_o", d_burst_o, '0);
        reset_n = 1'b1;
        tick();

        // ---- Fill at 0x1044, back-to-back beats ----
        d_address_i = 32'h0000_1044;
        d_read_i    = 1'b1;
        tick();
        d_read_i    = 1'b0;
        d_address_i = 32'hFFFF_FFFF;
        check_eq("rd_read_o_rise", {d_read_o, d_write_o}, 2'b10);
        check_eq("rd_addr_o", d_address_o, 32'h0000_1040);
        for (int k = 0; k < 4; k++) begin
            d_resp_i  = 1'b1;
            d_burst_i = 64'h1111_1111_1111_1111 * 64'(k + 1);
            tick();
            if (k < 3) check_eq($sformatf("rd_mid%0d", k), {d_read_o, d_resp_o}, 2'b10);
        end
        d_resp_i = 1'b0;
        check_eq("rd_done", {d_read_o, d_resp_o}, 2'b01);
        exp_line = {64'h4444_4444_4444_4444, 64'h3333_3333_3333_3333,
                    64'h2222_2222_2222_2222, 64'h1111_1111_1111_1111};
        check_eq("rd_line", d_line_o, exp_line);
        tick();
        check_eq("rd_resp_drop", d_resp_o, 1'b0);
        check_eq("rd_line_hold", d_line_o, exp_line);

        // ---- Writeback at 0x2000, 3-cycle stall between beats 1 and 2 ----
        wl = {64'hDEAD_3333_3333_3333, 64'h2222_2222_2222_2222,
              64'h1111_1111_1111_1111, 64'h0000_0000_0000_BEEF};
        d_line_i    = wl;
        d_address_i = 32'h0000_2000;
        d_write_i   = 1'b1;
        tick();
        d_write_i   = 1'b0;
        d_line_i    = '0;
        d_address_i = '0;
        check_eq("wr_strobes", {d_read_o, d_write_o}, 2'b01);
        check_eq("wr_addr_o", d_address_o, 32'h0000_2000);
        for (int k = 0; k < 4; k++) begin
            check_eq($sformatf("wr_burst%0d", k), d_burst_o, wl[k*64 +: 64]);
            if (k == 2) begin
                d_resp_i = 1'b0;
                for (int s = 0; s < 3; s++) begin
                    tick();
                    check_eq($sformatf("wr_stall%0d", s), {d_write_o, d_burst_o},
                             {1'b1, wl[128 +: 64]});
                end
            end
            d_resp_i = 1'b1;
            tick();
        end
        d_resp_i = 1'b0;
        check_eq("wr_done", {d_write_o, d_resp_o}, 2'b01);
        tick();

        // ---- read_i and write_i together: write first, then read ----
        cnt_snap    = d_resp_cnt;
        d_line_i    = ~wl;
        d_address_i = 32'h0000_3000;
        d_read_i    = 1'b1;
        d_write_i   = 1'b1;
        tick();
        d_write_i   = 1'b0;
        check_eq("both_write_first", {d_read_o, d_write_o}, 2'b01);
        d_resp_i = 1'b1;
        repeat (4) tick();
        d_resp_i = 1'b0;
        check_eq("both_wr_done", {d_write_o, d_resp_o}, 2'b01);
        tick();
        check_eq("both_idle", {d_read_o, d_write_o, d_resp_o}, 3'b000);
        tick();
        d_read_i = 1'b0;
        check_eq("both_read_next", {d_read_o, d_write_o}, 2'b10);
        check_eq("both_rd_addr", d_address_o, 32'h0000_3000);
        for (int k = 0; k < 4; k++) begin
            d_resp_i  = 1'b1;
            d_burst_i = 64'hA0A0_0000_0000_0000 + 64'(k);
            tick();
        end
        d_resp_i = 1'b0;
        check_eq("both_rd_done", d_resp_o, 1'b1);
        check_eq("both_rd_line", d_line_o,
                 {64'hA0A0_0000_0000_0003, 64'hA0A0_0000_0000_0002,
                  64'hA0A0_0000_0000_0001, 64'hA0A0_0000_0000_0000});
        tick();
        check_eq("both_resp_count", d_resp_cnt - cnt_snap, 2);

        // ---- Reset in the middle of a fill ----
        d_address_i = 32'h0000_4000;
        d_read_i    = 1'b1;
        tick();
        d_read_i    = 1'b0;
        d_resp_i    = 1'b1;
        d_burst_i   = 64'h5555_5555_5555_5555;
        tick();
        d_burst_i   = 64'h6666_6666_6666_6666;
        tick();
        d_resp_i    = 1'b0;
        cnt_snap    = d_resp_cnt;
        #2 reset_n  = 1'b0;
        #1;
        check_eq("arst_strobes", {d_read_o, d_write_o, d_resp_o}, 3'b000);
        check_eq("arst_line", d_line_o, '0);
        check_eq("arst_addr", d_address_o, '0);
        @(negedge clk);
        reset_n = 1'b1;
        tick();
        tick();
        check_eq("arst_no_resp", d_resp_cnt - cnt_snap, 0);
        d_address_i = 32'h0000_4008;
        d_read_i    = 1'b1;
        tick();
        d_read_i    = 1'b0;
        check_eq("arst_rd_addr", d_address_o, 32'h0000_4000);
        for (int k = 0; k < 4; k++) begin
            d_resp_i  = 1'b1;
            d_burst_i = 64'h7700_0000_0000_0000 + 64'(k);
            tick();
        end
        d_resp_i = 1'b0;
        check_eq("arst_rd_done", d_resp_o, 1'b1);
        check_eq("arst_rd_line", d_line_o,
                 {64'h7700_0000_0000_0003, 64'h7700_0000_0000_0002,
                  64'h7700_0000_0000_0001, 64'h7700_0000_0000_0000});
        tick();

        // ---- Wrapping fill at 0x1050 (critical beat 2) ----
        for (int b = 0; b < 4; b++) mem[b] = 64'h1111_1111_1111_1111 * 64'(b + 1);
        w_address_i = 32'h0000_1050;
        w_read_i    = 1'b1;
        tick();
        w_read_i    = 1'b0;
        check_eq("wrap_addr_o", w_address_o, 32'h0000_1050);
        check_eq("wrap_read_o", w_read_o, 1'b1);
        for (int k = 0; k < 4; k++) begin
            w_resp_i  = 1'b1;
            w_burst_i = mem[(k + 2) % 4];
            tick();
            if (k == 0) check_eq("wrap_first_slice", w_line_o[128 +: 64], mem[2]);
        end
        w_resp_i = 1'b0;
        check_eq("wrap_done", {w_read_o, w_resp_o}, 2'b01);
        check_eq("wrap_line", w_line_o, {mem[3], mem[2], mem[1], mem[0]});
        tick();

        // ---- Wide: 512/32, 16 beats, 64-byte alignment ----
        x_address_i = 32'h0000_5074;
        x_read_i    = 1'b1;
        tick();
        x_read_i    = 1'b0;
        check_eq("wide_addr_o", x_address_o, 32'h0000_5040);
        exp_wide = '0;
        for (int k = 0; k < 16; k++) begin
            x_resp_i  = 1'b1;
            x_burst_i = 32'hA000_0000 + 32'(k);
            exp_wide[k*32 +: 32] = 32'hA000_0000 + 32'(k);
            tick();
            if (k < 15) check_eq($sformatf("wide_mid%0d", k), {x_read_o, x_resp_o}, 2'b10);
        end
        x_resp_i = 1'b0;
        check_eq("wide_done", {x_read_o, x_resp_o}, 2'b01);
        check_eq("wide_line", x_line_o, exp_wide);
        tick();

        check_eq("d_resp_total", d_resp_cnt, 5);
        check_eq("w_resp_total", w_resp_cnt, 1);
        check_eq("x_resp_total", x_resp_cnt, 1);
        check_eq("rd_wr_exclusive", both_hi, 0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
